// File: rtl/updn_mon_pkg.sv
// Shared constants for the up/down counter monitor: step classification codes,
// FSM state encoding and a small helper used by the top level.
package updn_mon_pkg;

    // Step classification codes driven on the dir output
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;
    localparam logic [1:0] DIR_ILL  = 2'b11;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,   // no reference sample yet
        ST_TRACK = 2'd1,   // following the counter step by step
        ST_FAULT = 2'd2    // too many illegal steps, waiting for a clean run
    } state_t;

    // A step is legal when it is a hold, an up or a down
    function automatic logic dir_is_legal(input logic [1:0] code);
        return code != DIR_ILL;
    endfunction

endpackage

// File: rtl/updn_step_classify.sv
// Combinational step classifier: compares the previous and current counter
// samples and reports hold / up / down / illegal plus the two wrap events.
// For W=1 a difference of 1 is both +1 and -1; it is reported as up.
module updn_step_classify
    import updn_mon_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] q_in,
    output logic [1:0]   dir,
    output logic         wrap_up,
    output logic         wrap_dn
);

    localparam logic [W-1:0] ZERO_V = '0;
    localparam logic [W-1:0] ONE_V  = W'(1);
    localparam logic [W-1:0] MAX_V  = '1;

    logic [W-1:0] diff;

    // Modulo-2^W difference between the new and the reference sample
    assign diff = q_in - prev;

    // Classify the step; up is tested before down so W=1 resolves to up
    always_comb begin
        dir = DIR_ILL;
        if (diff == ZERO_V) begin
            dir = DIR_HOLD;
        end else if (diff == ONE_V) begin
            dir = DIR_UP;
        end else if (diff == MAX_V) begin
            dir = DIR_DN;
        end
    end

    assign wrap_up = (prev == MAX_V)  && (q_in == ZERO_V);
    assign wrap_dn = (prev == ZERO_V) && (q_in == MAX_V);

endmodule

// File: rtl/updn_count_monitor.sv
// Up/down counter monitor. Samples q_in on each valid strobe, classifies the
// step against the previous sample, raises wrap and error pulses, keeps an
// extended signed position and drops into a fault state after ERR_LIMIT
// consecutive illegal steps. Two consecutive legal steps leave the fault
// state and resynchronise on the following sample.
// Optional build macro: UPDN_MON_STICKY_EN adds the err_sticky output, a flag
// set by any step error and cleared only by reset.
module updn_count_monitor
    import updn_mon_pkg::*;
#(
    parameter int W         = 4,
    parameter int PW        = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [W-1:0]         q_in,
    input  logic                 ud_exp,
    output logic [1:0]           dir,
    output logic                 step_err,
    output logic                 wrap_up,
    output logic                 wrap_dn,
    output logic signed [PW-1:0] pos,
    output logic                 fault
`ifdef UPDN_MON_STICKY_EN
    ,
    output logic                 err_sticky
`endif
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);

    state_t                state_reg, state_next;
    logic [ERR_W-1:0]      err_run_reg, err_run_next;
    logic                  rec_reg, rec_next;      // one legal step already seen in FAULT
    logic [W-1:0]          prev_reg, prev_next;
    logic signed [PW-1:0]  pos_reg, pos_next;
    logic [1:0]            dir_reg, dir_next;
    logic                  step_err_reg, step_err_next;
    logic                  wrap_up_reg, wrap_up_next;
    logic                  wrap_dn_reg, wrap_dn_next;

    logic [1:0]            cls_dir;
    logic                  cls_wrap_up;
    logic                  cls_wrap_dn;
    logic                  step_legal;

    updn_step_classify #(
        .W (W)
    ) u_classify (
        .prev    (prev_reg),
        .q_in    (q_in),
        .dir     (cls_dir),
        .wrap_up (cls_wrap_up),
        .wrap_dn (cls_wrap_dn)
    );

    assign step_legal = dir_is_legal(cls_dir);

    // State register together with the error-run and recovery counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_SYNC;
            err_run_reg <= '0;
            rec_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_run_reg <= err_run_next;
            rec_reg     <= rec_next;
        end
    end

    // Next-state logic: sync on first sample, count illegal runs, recover from fault
    always_comb begin
        state_next   = state_reg;
        err_run_next = err_run_reg;
        rec_next     = rec_reg;
        case (state_reg)
            ST_SYNC: begin
                if (valid) begin
                    state_next   = ST_TRACK;
                    err_run_next = '0;
                end
            end
            ST_TRACK: begin
                if (valid) begin
                    if (step_legal) begin
                        err_run_next = '0;
                    end else begin
                        if (err_run_reg != ERR_MAX) begin
                            err_run_next = err_run_reg + ERR_W'(1);
                        end
                        if (err_run_next == ERR_MAX) begin
                            state_next = ST_FAULT;
                            rec_next   = 1'b0;
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (valid) begin
                    if (step_legal) begin
                        if (rec_reg) begin
                            state_next   = ST_SYNC;
                            rec_next     = 1'b0;
                            err_run_next = '0;
                        end else begin
                            rec_next = 1'b1;
                        end
                    end else begin
                        rec_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next   = ST_SYNC;
                err_run_next = '0;
                rec_next     = 1'b0;
            end
        endcase
    end

    // Output logic: next values of the registered flags, position and reference
    always_comb begin
        prev_next     = prev_reg;
        pos_next      = pos_reg;
        dir_next      = dir_reg;
        step_err_next = 1'b0;
        wrap_up_next  = 1'b0;
        wrap_dn_next  = 1'b0;
        if (valid) begin
            prev_next = q_in;
            case (state_reg)
                ST_SYNC: begin
                    pos_next = $signed({{(PW-W){1'b0}}, q_in});
                    dir_next = DIR_HOLD;
                end
                ST_TRACK: begin
                    dir_next     = cls_dir;
                    wrap_up_next = cls_wrap_up;
                    wrap_dn_next = cls_wrap_dn;
                    case (cls_dir)
                        DIR_UP: begin
                            pos_next      = pos_reg + PW'(1);
                            step_err_next = ud_exp;
                        end
                        DIR_DN: begin
                            pos_next      = pos_reg - PW'(1);
                            step_err_next = ~ud_exp;
                        end
                        DIR_ILL: begin
                            step_err_next = 1'b1;
                        end
                        default: begin
                            step_err_next = 1'b0;
                        end
                    endcase
                end
                ST_FAULT: begin
                    // Position and pulses frozen; dir returns to hold on leaving fault
                    if (state_next == ST_SYNC) begin
                        dir_next = DIR_HOLD;
                    end
                end
                default: begin
                    dir_next = DIR_HOLD;
                end
            endcase
        end
    end

    // Registered outputs and reference sample
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg     <= '0;
            pos_reg      <= '0;
            dir_reg      <= DIR_HOLD;
            step_err_reg <= 1'b0;
            wrap_up_reg  <= 1'b0;
            wrap_dn_reg  <= 1'b0;
        end else begin
            prev_reg     <= prev_next;
            pos_reg      <= pos_next;
            dir_reg      <= dir_next;
            step_err_reg <= step_err_next;
            wrap_up_reg  <= wrap_up_next;
            wrap_dn_reg  <= wrap_dn_next;
        end
    end

    assign dir      = dir_reg;
    assign step_err = step_err_reg;
    assign wrap_up  = wrap_up_reg;
    assign wrap_dn  = wrap_dn_reg;
    assign pos      = pos_reg;
    assign fault    = (state_reg == ST_FAULT);

`ifdef UPDN_MON_STICKY_EN
    logic err_sticky_reg;

    // Sticky error flag: any step error latches it until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_reg <= 1'b0;
        end else if (step_err_next) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_reg;
`endif

endmodule

// File: tb/tb_updn_count_monitor.sv
// Directed self-checking bench for updn_count_monitor (W=4, PW=8, ERR_LIMIT=3).
// Build with UPDN_MON_STICKY_EN defined to also exercise err_sticky.
module tb_updn_count_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       ud_exp = 1'b0;
    logic [1:0] dir;
    logic       step_err;
    logic       wrap_up;
    logic       wrap_dn;
    logic [7:0] pos;
    logic       fault;
`ifdef UPDN_MON_STICKY_EN
    logic       err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    updn_count_monitor #(
        .W         (4),
        .PW        (8),
        .ERR_LIMIT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .q_in       (q_in),
        .ud_exp     (ud_exp),
        .dir        (dir),
        .step_err   (step_err),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .pos        (pos),
        .fault      (fault)
`ifdef UPDN_MON_STICKY_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic cycle(input logic r, input logic v, input logic [3:0] q, input logic ud);
        @(negedge clk);
        reset  = r;
        valid  = v;
        q_in   = q;
        ud_exp = ud;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b v=%b q=%0d ud=%b -> dir=%b serr=%b wu=%b wd=%b pos=%0d flt=%b",
                 $time, r, v, q, ud, dir, step_err, wrap_up, wrap_dn, pos, fault);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        n_checks++; if (dir !== 2'b00)   begin n_fail++; $display("FAIL reset_dir: got %b expected 00", dir); end
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL reset_step_err: got %b expected 0", step_err); end
        n_checks++; if ({wrap_up, wrap_dn} !== 2'b00) begin n_fail++; $display("FAIL reset_wrap: got %b expected 00", {wrap_up, wrap_dn}); end
        n_checks++; if (pos !== 8'h00)   begin n_fail++; $display("FAIL reset_pos: got %h expected 00", pos); end
        n_checks++; if (fault !== 1'b0)  begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    // Count 0..15 then wrap to 0, direction up expected
    task automatic test_count_up;
        int wraps;
        wraps = 0;
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        n_checks++; if (dir !== 2'b00 || pos !== 8'd0) begin n_fail++; $display("FAIL up_sync: got dir=%b pos=%h expected dir=00 pos=00", dir, pos); end
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b1, 4'(k), 1'b0);
            if (wrap_up === 1'b1) wraps++;
            n_checks++; if (dir !== 2'b01) begin n_fail++; $display("FAIL up_dir k=%0d: got %b expected 01", k, dir); end
            n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL up_step_err k=%0d: got %b expected 0", k, step_err); end
            n_checks++; if (wrap_up !== (k == 16)) begin n_fail++; $display("FAIL up_wrap k=%0d: got %b expected %b", k, wrap_up, (k == 16)); end
            n_checks++; if (pos !== 8'(k)) begin n_fail++; $display("FAIL up_pos k=%0d: got %0d expected %0d", k, pos, k); end
        end
        n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL up_wrap_count: got %0d expected 1", wraps); end
        // No strobe: pulses must drop, position and direction hold
        cycle(1'b0, 1'b0, 4'd7, 1'b0);
        n_checks++; if ({step_err, wrap_up, wrap_dn} !== 3'b000) begin n_fail++; $display("FAIL idle_pulses: got %b expected 000", {step_err, wrap_up, wrap_dn}); end
        n_checks++; if (pos !== 8'd16 || dir !== 2'b01) begin n_fail++; $display("FAIL idle_hold: got pos=%0d dir=%b expected pos=16 dir=01", pos, dir); end
    endtask

    // Count 3,2,1,0,15 with down expected; ends at -1
    task automatic test_count_down;
        logic [3:0] seq [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
        cycle(1'b1, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 1'b1, seq[0], 1'b1);
        n_checks++; if (pos !== 8'd3) begin n_fail++; $display("FAIL dn_sync_pos: got %0d expected 3", pos); end
        for (int i = 1; i < 5; i++) begin
            cycle(1'b0, 1'b1, seq[i], 1'b1);
            n_checks++; if (dir !== 2'b10) begin n_fail++; $display("FAIL dn_dir i=%0d: got %b expected 10", i, dir); end
            n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL dn_step_err i=%0d: got %b expected 0", i, step_err); end
            n_checks++; if (wrap_dn !== (i == 4) || wrap_up !== 1'b0) begin n_fail++; $display("FAIL dn_wrap i=%0d: got wd=%b wu=%b expected wd=%b wu=0", i, wrap_dn, wrap_up, (i == 4)); end
            n_checks++; if (pos !== 8'(3 - i)) begin n_fail++; $display("FAIL dn_pos i=%0d: got %h expected %h", i, pos, 8'(3 - i)); end
        end
    endtask

    // Legal step against the expected direction
    task automatic test_wrong_direction;
        cycle(1'b1, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 1'b1, 4'd4, 1'b1);
        cycle(1'b0, 1'b1, 4'd5, 1'b1);
        n_checks++; if (dir !== 2'b01 || step_err !== 1'b1 || pos !== 8'd5) begin n_fail++; $display("FAIL wrongdir_up: got dir=%b serr=%b pos=%0d expected 01 1 5", dir, step_err, pos); end
        cycle(1'b0, 1'b1, 4'd4, 1'b1);
        n_checks++; if (dir !== 2'b10 || step_err !== 1'b0 || pos !== 8'd4) begin n_fail++; $display("FAIL rightdir_dn: got dir=%b serr=%b pos=%0d expected 10 0 4", dir, step_err, pos); end
        cycle(1'b0, 1'b1, 4'd5, 1'b0);
        cycle(1'b0, 1'b1, 4'd4, 1'b0);
        n_checks++; if (dir !== 2'b10 || step_err !== 1'b1 || pos !== 8'd4) begin n_fail++; $display("FAIL wrongdir_dn: got dir=%b serr=%b pos=%0d expected 10 1 4", dir, step_err, pos); end
        cycle(1'b0, 1'b1, 4'd4, 1'b0);
        n_checks++; if (dir !== 2'b00 || step_err !== 1'b0 || pos !== 8'd4) begin n_fail++; $display("FAIL hold: got dir=%b serr=%b pos=%0d expected 00 0 4", dir, step_err, pos); end
    endtask

    // A legal step between illegal ones restarts the error run
    task automatic test_err_run_clear;
        logic [3:0] seq [6] = '{4'd5, 4'd9, 4'd10, 4'd0, 4'd4, 4'd8};
        logic       exp_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, seq[i], 1'b0);
            n_checks++; if (fault !== exp_f[i]) begin n_fail++; $display("FAIL errclr_fault i=%0d: got %b expected %b", i, fault, exp_f[i]); end
        end
    endtask

    // Enter fault on three illegal steps, recover on two consecutive legal ones
    task automatic test_fault;
        logic [3:0] seq [11]  = '{4'd5, 4'd9, 4'd13, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd7, 4'd8, 4'd9};
        logic       exp_e [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_f [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_p [11] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd7, 8'd8, 8'd9};
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, 1'b1, seq[i], 1'b0);
            n_checks++; if (step_err !== exp_e[i]) begin n_fail++; $display("FAIL fault_step_err i=%0d: got %b expected %b", i, step_err, exp_e[i]); end
            n_checks++; if (fault !== exp_f[i]) begin n_fail++; $display("FAIL fault_flag i=%0d: got %b expected %b", i, fault, exp_f[i]); end
            n_checks++; if (pos !== exp_p[i]) begin n_fail++; $display("FAIL fault_pos i=%0d: got %0d expected %0d", i, pos, exp_p[i]); end
        end
        n_checks++; if (dir !== 2'b01) begin n_fail++; $display("FAIL fault_resync_dir: got %b expected 01", dir); end
    endtask

    // Reset together with a strobe while in fault
    task automatic test_reset_in_fault;
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 4'd5, 1'b0);
        cycle(1'b0, 1'b1, 4'd9, 1'b0);
        cycle(1'b0, 1'b1, 4'd13, 1'b0);
        cycle(1'b0, 1'b1, 4'd1, 1'b0);
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL rstflt_enter: got %b expected 1", fault); end
        cycle(1'b1, 1'b1, 4'd2, 1'b0);
        n_checks++; if ({dir, step_err, wrap_up, wrap_dn, fault} !== 6'b0 || pos !== 8'd0) begin n_fail++; $display("FAIL rstflt_outputs: got dir=%b serr=%b wu=%b wd=%b flt=%b pos=%0d expected all 0", dir, step_err, wrap_up, wrap_dn, fault, pos); end
        cycle(1'b0, 1'b1, 4'd6, 1'b0);
        n_checks++; if (pos !== 8'd6 || dir !== 2'b00 || step_err !== 1'b0) begin n_fail++; $display("FAIL rstflt_sync: got pos=%0d dir=%b serr=%b expected 6 00 0", pos, dir, step_err); end
    endtask

`ifdef UPDN_MON_STICKY_EN
    task automatic test_sticky;
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_reset: got %b expected 0", err_sticky); end
        cycle(1'b0, 1'b1, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 4'd5, 1'b0);
        n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set: got %b expected 1", err_sticky); end
        for (int i = 6; i < 26; i++) begin
            cycle(1'b0, 1'b1, 4'(i), 1'b0);
            n_checks++; if (err_sticky !== 1'b1 || step_err !== 1'b0) begin n_fail++; $display("FAIL sticky_hold i=%0d: got sticky=%b serr=%b expected 1 0", i, err_sticky, step_err); end
        end
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b expected 0", err_sticky); end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_wrong_direction();
        test_err_run_clear();
        test_fault();
        test_reset_in_fault();
`ifdef UPDN_MON_STICKY_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
